// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared constants and types for the serial pattern detector
package pattern_pkg;

    localparam int PAT_W_MAX = 16;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    localparam int FILL_W = $clog2(PAT_W_MAX + 1);

    typedef logic [FILL_W-1:0] fill_t;

    // Fill count saturates at the pattern length so a long run of bits never wraps it.
    function automatic fill_t fill_inc(input fill_t f, input int lim);
        if (int'(f) >= lim) begin
            return f;
        end
        return f + fill_t'(1);
    endfunction

endpackage

// File: rtl/pattern_det_if.sv
// rtl/pattern_det_if.sv - bit stream, pattern load and match status bundle (msk_in only with PATTERN_DET_MASK_EN)
interface pattern_det_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) ();

    logic             i_vld;
    logic             i;
    logic             pat_ld;
    logic [PAT_W-1:0] pat_in;
`ifdef PATTERN_DET_MASK_EN
    logic [PAT_W-1:0] msk_in;
`endif
    logic             ovl;
    logic             clr;
    logic             o;
    logic [CNT_W-1:0] cnt;

`ifdef PATTERN_DET_MASK_EN
    modport master (
        output i_vld, i, pat_ld, pat_in, msk_in, ovl, clr,
        input  o, cnt
    );

    modport slave (
        input  i_vld, i, pat_ld, pat_in, msk_in, ovl, clr,
        output o, cnt
    );
`else
    modport master (
        output i_vld, i, pat_ld, pat_in, ovl, clr,
        input  o, cnt
    );

    modport slave (
        input  i_vld, i, pat_ld, pat_in, ovl, clr,
        output o, cnt
    );
`endif

endinterface

// File: rtl/pattern_hist.sv
// rtl/pattern_hist.sv - history shift register and saturating fill counter
module pattern_hist
    import pattern_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic             clr,
    output logic [PAT_W-1:0] hist,
    output logic             full
);

    logic [PAT_W-1:0] hist_q;
    fill_t            fill_q;
    fill_t            fill_nxt;

    // hist/full are look-ahead values: what the registers hold after this edge,
    // before any clear, so the comparator can flag the match on the same edge.
    always_comb begin
        hist     = hist_q;
        fill_nxt = fill_q;
        if (shift_en) begin
            hist     = {hist_q[PAT_W-2:0], bit_in};
            fill_nxt = fill_inc(fill_q, PAT_W);
        end
    end

    assign full = (fill_nxt == fill_t'(PAT_W));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist;
            fill_q <= clr ? fill_t'(0) : fill_nxt;
        end
    end

endmodule

// File: rtl/pattern_det.sv
// rtl/pattern_det.sv - loadable serial pattern detector with saturating match counter; PATTERN_DET_MASK_EN adds a don't-care mask
module pattern_det
    import pattern_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b0110),
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    pattern_det_if.slave     bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] msk_q;
    logic [PAT_W-1:0] hist_nxt;
    logic             full_nxt;
    logic             shift_en;
    logic             match;
    logic             hist_clr;
    logic             o_q;
    logic [CNT_W-1:0] cnt_q;

    // A pattern load drops the bit presented in the same cycle.
    assign shift_en = bus.i_vld & ~bus.pat_ld;

    pattern_hist #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk      (clk),
        .rst_b    (rst_b),
        .shift_en (shift_en),
        .bit_in   (bus.i),
        .clr      (hist_clr),
        .hist     (hist_nxt),
        .full     (full_nxt)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pat_q <= PAT_RST;
        end else if (bus.pat_ld) begin
            pat_q <= bus.pat_in;
        end
    end

`ifdef PATTERN_DET_MASK_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            msk_q <= '1;
        end else if (bus.pat_ld) begin
            msk_q <= bus.msk_in;
        end
    end
`else
    assign msk_q = '1;
`endif

    assign match    = shift_en & full_nxt & (((hist_nxt ^ pat_q) & msk_q) == '0);
    assign hist_clr = bus.pat_ld | (match & (bus.ovl == OVL_OFF));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            o_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            o_q <= match;
            if (bus.clr) begin
                cnt_q <= '0;
            end else if (match && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.o   = o_q;
    assign bus.cnt = cnt_q;

endmodule

// File: tb/tb_pattern_det.sv
// tb/tb_pattern_det.sv - randomized and directed bench for pattern_det against a bit-queue reference model
module tb_pattern_det;
    import pattern_pkg::*;

    localparam int PW   = 4;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    pattern_det_if #(.PAT_W(PW), .CNT_W(CW)) bus ();

    pattern_det #(
        .PAT_W   (PW),
        .PAT_RST (4'b0110),
        .CNT_W   (CW)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    bit            q[$];
    logic [PW-1:0] m_pat;
    logic [PW-1:0] m_msk;
    logic [PW-1:0] drv_msk = '1;
    int            m_cnt;
    bit            m_o;

    function automatic logic [PW-1:0] window();
        logic [PW-1:0] w = '0;
        foreach (q[k]) w = {w[PW-2:0], q[k]};
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pat = 4'b0110;
        m_msk = '1;
        m_cnt = 0;
        m_o   = 1'b0;
    endtask

    task automatic drive_idle();
        bus.i_vld  = 1'b0;
        bus.i      = 1'b0;
        bus.pat_ld = 1'b0;
        bus.pat_in = '0;
`ifdef PATTERN_DET_MASK_EN
        bus.msk_in = '1;
`endif
        bus.ovl    = OVL_ON;
        bus.clr    = 1'b0;
    endtask

    // Drive one cycle from a negedge, advance the model on the posedge, return on the next negedge.
    task automatic step(input bit vld, input bit b, input bit ld, input logic [PW-1:0] pin,
                        input bit ov, input bit cl);
        bus.i_vld  = vld;
        bus.i      = b;
        bus.pat_ld = ld;
        bus.pat_in = pin;
`ifdef PATTERN_DET_MASK_EN
        bus.msk_in = drv_msk;
`endif
        bus.ovl    = ov;
        bus.clr    = cl;
        @(posedge clk);
        m_o = 1'b0;
        if (ld) begin
            m_pat = pin;
            m_msk = drv_msk;
            q.delete();
        end else if (vld) begin
            q.push_back(b);
            if (q.size() > PW) void'(q.pop_front());
            if (q.size() == PW && ((window() ^ m_pat) & m_msk) == '0) begin
                m_o = 1'b1;
                if (!ov) q.delete();
            end
        end
        if (cl) m_cnt = 0;
        else if (m_o && m_cnt < CMAX) m_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle();
        rst_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        drive_idle();
        rst_b     = 1'b0;
        bus.i_vld = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.i = 1'(k == 1 || k == 2 || k == 4);
            @(negedge clk);
            checks++;
            if (bus.o !== 1'b0) begin
                errors++;
                $display("FAIL reset_o: got %0b expected 0", bus.o);
            end
            checks++;
            if (bus.cnt !== 2'd0) begin
                errors++;
                $display("FAIL reset_cnt: got %0d expected 0", bus.cnt);
            end
            checks++;
            if (dut.pat_q !== 4'b0110) begin
                errors++;
                $display("FAIL reset_pat: got %b expected 0110", dut.pat_q);
            end
        end
        drive_idle();
        rst_b = 1'b1;
        model_reset();
    endtask

    task automatic run_0110110(input bit ov, input logic [6:0] exp_o, input int exp_cnt, input string tag);
        logic [6:0] bits = 7'b0110110;
        do_reset();
        for (int k = 6; k >= 0; k--) begin
            step(1'b1, bits[k], 1'b0, '0, ov, 1'b0);
            checks++;
            if (bus.o !== exp_o[k]) begin
                errors++;
                $display("FAIL %s_o bit%0d: got %0b expected %0b", tag, 7 - k, bus.o, exp_o[k]);
            end
        end
        checks++;
        if (int'(bus.cnt) !== exp_cnt) begin
            errors++;
            $display("FAIL %s_cnt: got %0d expected %0d", tag, bus.cnt, exp_cnt);
        end
    endtask

    task automatic test_overlap();
        run_0110110(OVL_ON, 7'b0001001, 2, "overlap");
    endtask

    task automatic test_nonoverlap();
        run_0110110(OVL_OFF, 7'b0001000, 1, "nonoverlap");
    endtask

    task automatic test_gaps();
        do_reset();
        step(1'b1, 1'b0, 1'b0, '0, OVL_ON, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, OVL_ON, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, OVL_ON, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'($urandom_range(1)), 1'b0, '0, OVL_ON, 1'b0);
            checks++;
            if (bus.o !== 1'b0) begin
                errors++;
                $display("FAIL gap_idle_o: got %0b expected 0", bus.o);
            end
        end
        step(1'b1, 1'b0, 1'b0, '0, OVL_ON, 1'b0);
        checks++;
        if (bus.o !== 1'b1) begin
            errors++;
            $display("FAIL gap_match_o: got %0b expected 1", bus.o);
        end
        step(1'b0, 1'b0, 1'b0, '0, OVL_ON, 1'b0);
        checks++;
        if (bus.o !== 1'b0 || bus.cnt !== 2'd1) begin
            errors++;
            $display("FAIL gap_after: got o=%0b cnt=%0d expected o=0 cnt=1", bus.o, bus.cnt);
        end
    endtask

    task automatic test_load();
        logic [3:0] bits  = 4'b1011;
        logic [3:0] exp_o = 4'b0001;
        do_reset();
        step(1'b1, 1'b1, 1'b1, 4'b1011, OVL_ON, 1'b0);
        checks++;
        if (bus.o !== 1'b0 || dut.pat_q !== 4'b1011) begin
            errors++;
            $display("FAIL load_cycle: got o=%0b pat=%b expected o=0 pat=1011", bus.o, dut.pat_q);
        end
        for (int k = 3; k >= 0; k--) begin
            step(1'b1, bits[k], 1'b0, '0, OVL_ON, 1'b0);
            checks++;
            if (bus.o !== exp_o[k]) begin
                errors++;
                $display("FAIL load_o bit%0d: got %0b expected %0b", 4 - k, bus.o, exp_o[k]);
            end
        end
        checks++;
        if (bus.cnt !== 2'd1) begin
            errors++;
            $display("FAIL load_cnt: got %0d expected 1", bus.cnt);
        end
    endtask

    task automatic test_counter();
        int exp_c;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 4'b1111, OVL_ON, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b1, 1'b0, '0, OVL_ON, 1'b0);
            exp_c = (k < 4) ? 0 : ((k - 3 > 3) ? 3 : k - 3);
            checks++;
            if (bus.o !== 1'(k >= 4) || int'(bus.cnt) !== exp_c) begin
                errors++;
                $display("FAIL sat bit%0d: got o=%0b cnt=%0d expected o=%0b cnt=%0d",
                         k, bus.o, bus.cnt, k >= 4, exp_c);
            end
        end
        step(1'b1, 1'b1, 1'b0, '0, OVL_ON, 1'b1);
        checks++;
        if (bus.o !== 1'b1 || bus.cnt !== 2'd0) begin
            errors++;
            $display("FAIL clr_on_match: got o=%0b cnt=%0d expected o=1 cnt=0", bus.o, bus.cnt);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b1, 1'b0, '0, OVL_ON, 1'b0);
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (bus.o !== 1'b0 || bus.cnt !== 2'd0 || dut.pat_q !== 4'b0110) begin
            errors++;
            $display("FAIL async_reset: got o=%0b cnt=%0d pat=%b expected o=0 cnt=0 pat=0110",
                     bus.o, bus.cnt, dut.pat_q);
        end
        @(negedge clk);
        drive_idle();
        rst_b = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int n_match = 0;
        bit ld;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            ld = ($urandom_range(24) == 0);
`ifdef PATTERN_DET_MASK_EN
            if (ld) drv_msk = PW'($urandom);
`endif
            step(1'($urandom_range(5) != 0), 1'($urandom), ld, PW'($urandom),
                 1'($urandom), $urandom_range(30) == 0);
            if (m_o) n_match++;
            checks++;
            if (bus.o !== m_o || int'(bus.cnt) !== m_cnt) begin
                errors++;
                $display("FAIL random cyc%0d: got o=%0b cnt=%0d expected o=%0b cnt=%0d",
                         k, bus.o, bus.cnt, m_o, m_cnt);
            end
        end
        drv_msk = '1;
        checks++;
        if (n_match == 0) begin
            errors++;
            $display("FAIL random_coverage: got 0 matches expected at least 1");
        end
    endtask

`ifdef PATTERN_DET_MASK_EN
    task automatic test_mask();
        logic [3:0] bits = 4'b1101;
        do_reset();
        drv_msk = 4'b1001;
        step(1'b0, 1'b0, 1'b1, 4'b1001, OVL_ON, 1'b0);
        for (int k = 3; k >= 0; k--) step(1'b1, bits[k], 1'b0, '0, OVL_ON, 1'b0);
        checks++;
        if (bus.o !== 1'b1 || bus.cnt !== 2'd1) begin
            errors++;
            $display("FAIL mask_match: got o=%0b cnt=%0d expected o=1 cnt=1", bus.o, bus.cnt);
        end
        drv_msk = '1;
    endtask
`endif

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gaps();
        test_load();
        test_counter();
        test_async_reset();
        test_random();
`ifdef PATTERN_DET_MASK_EN
        test_mask();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
